bsg_dff_reset_n_two_entry_reader: RTL and testbench

// - Read-side counterpart of the enable-gated reset register.
// - The producer writes words with a valid/ready handshake into 2 register entries.
// - The consumer drains them in order with a valid/yumi handshake.
// - Sits between a block that loads a value with en and a downstream unit that may stall.
// - Holds up to two words, so the producer sees full throughput when the consumer accepts every cycle.

---
 rtl/bsg_dff_reset_n_two_entry_reader_if.sv | 24 ++
 rtl/bsg_dff_reset_n_two_entry_reader.sv | 57 +++++
 tb/tb_bsg_dff_reset_n_two_entry_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bsg_dff_reset_n_two_entry_reader_if.sv
// Handshake bundle for the two-entry reader: producer valid/ready in, consumer valid/yumi out.
// The master modport is the environment that drives words in and yumi; the slave modport is the block.
interface bsg_dff_reset_n_two_entry_reader_if #(
    parameter int width_p = 10
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic [1:0]         count_o;
    logic               err_o;

    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, count_o, err_o
    );

    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o, count_o, err_o
    );
endinterface

// File: rtl/bsg_dff_reset_n_two_entry_reader.sv
// Two-entry in-order buffer between an enable-loaded register and a stallable consumer.
// Every output comes from registered state only, so v_i and yumi_i never reach the outputs combinationally.
module bsg_dff_reset_n_two_entry_reader #(
    parameter int width_p = 10
) (
    input logic                                 clock_i,
    input logic                                 reset_n_i,
    bsg_dff_reset_n_two_entry_reader_if.slave   bus
);
    logic [width_p-1:0] mem [0:1];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               err;

    logic enq;
    logic deq;
    logic bad_yumi;

    assign bus.ready_o = (count != 2'd2);
    assign bus.v_o     = (count != 2'd0);
    assign bus.data_o  = mem[rd_ptr];
    assign bus.count_o = count;
    assign bus.err_o   = err;

    assign enq      = bus.v_i & bus.ready_o;
    assign deq      = bus.yumi_i & bus.v_o;
    assign bad_yumi = bus.yumi_i & ~bus.v_o;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= bus.data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous enq and deq leaves the occupancy unchanged.
            if (enq && !deq) begin
                count <= count + 2'd1;
            end else if (deq && !enq) begin
                count <= count - 2'd1;
            end
            if (bad_yumi) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bsg_dff_reset_n_two_entry_reader.sv
// Directed bench for the two-entry reader: reset, single word, fill/stall, full+yumi, streaming, error and async reset.
module tb_bsg_dff_reset_n_two_entry_reader;
    localparam int width_p = 10;

    logic clock_i;
    logic reset_n_i;
    int   checks;
    int   errors;

    bsg_dff_reset_n_two_entry_reader_if #(.width_p(width_p)) bus ();

    bsg_dff_reset_n_two_entry_reader #(.width_p(width_p)) dut (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i  = 1'b0;
        bus.v_i    = 1'b0;
        bus.data_i = '0;
        bus.yumi_i = 1'b0;
        step();
        step();
        checks++; if (bus.v_o !== 1'b0) begin errors++; $display("FAIL reset_in_v got %b want 0", bus.v_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.ready_o); end
        reset_n_i = 1'b1;
        step();
        checks++; if (bus.v_o !== 1'b0) begin errors++; $display("FAIL reset_v got %b want 0", bus.v_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
        checks++; if (bus.data_o !== 10'h000) begin errors++; $display("FAIL reset_data got %h want 000", bus.data_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_o); end
    endtask

    task automatic test_single_word();
        bus.v_i    = 1'b1;
        bus.data_i = 10'h2A5;
        step();
        bus.v_i = 1'b0;
        checks++; if (bus.v_o !== 1'b1) begin errors++; $display("FAIL single_v got %b want 1", bus.v_o); end
        checks++; if (bus.data_o !== 10'h2A5) begin errors++; $display("FAIL single_data got %h want 2a5", bus.data_o); end
        checks++; if (bus.count_o !== 2'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", bus.count_o); end
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", bus.count_o); end
        checks++; if (bus.v_o !== 1'b0) begin errors++; $display("FAIL single_v0 got %b want 0", bus.v_o); end
    endtask

    task automatic test_fill_stall();
        bus.v_i    = 1'b1;
        bus.data_i = 10'h001;
        step();
        bus.data_i = 10'h002;
        step();
        bus.data_i = 10'h003;
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", bus.ready_o); end
        checks++; if (bus.count_o !== 2'd2) begin errors++; $display("FAIL fill_count got %0d want 2", bus.count_o); end
        step();
        step();
        bus.v_i = 1'b0;
        checks++; if (bus.count_o !== 2'd2) begin errors++; $display("FAIL stall_count got %0d want 2", bus.count_o); end
        checks++; if (bus.data_o !== 10'h001) begin errors++; $display("FAIL stall_head got %h want 001", bus.data_o); end
        bus.yumi_i = 1'b1;
        step();
        checks++; if (bus.data_o !== 10'h002) begin errors++; $display("FAIL drain_second got %h want 002", bus.data_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", bus.ready_o); end
        step();
        bus.yumi_i = 1'b0;
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL drain_count got %0d want 0 (003 stored?)", bus.count_o); end
    endtask

    task automatic test_full_simul_yumi();
        bus.v_i    = 1'b1;
        bus.data_i = 10'h111;
        step();
        bus.data_i = 10'h222;
        step();
        bus.data_i = 10'h3FF;
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
        checks++; if (bus.count_o !== 2'd1) begin errors++; $display("FAIL fullyumi_count got %0d want 1", bus.count_o); end
        checks++; if (bus.data_o !== 10'h222) begin errors++; $display("FAIL fullyumi_head got %h want 222", bus.data_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL fullyumi_ready got %b want 1", bus.ready_o); end
        step();
        bus.v_i = 1'b0;
        checks++; if (bus.count_o !== 2'd2) begin errors++; $display("FAIL fullyumi_enq_count got %0d want 2", bus.count_o); end
        bus.yumi_i = 1'b1;
        step();
        checks++; if (bus.data_o !== 10'h3FF) begin errors++; $display("FAIL fullyumi_3ff got %h want 3ff", bus.data_o); end
        checks++; if (bus.count_o !== 2'd1) begin errors++; $display("FAIL fullyumi_drain1 got %0d want 1", bus.count_o); end
        step();
        bus.yumi_i = 1'b0;
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL fullyumi_drain0 got %0d want 0", bus.count_o); end
    endtask

    task automatic test_streaming();
        int exp_word;
        exp_word = 0;
        for (int i = 0; i < 100; i++) begin
            bus.v_i    = 1'b1;
            bus.data_i = 10'(i);
            bus.yumi_i = bus.v_o;
            if (bus.v_o === 1'b1) begin
                checks++; if (bus.data_o !== 10'(exp_word)) begin errors++; $display("FAIL stream_data got %0d want %0d", bus.data_o, exp_word); end
                exp_word++;
            end
            step();
        end
        bus.v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.yumi_i = bus.v_o;
            if (bus.v_o === 1'b1) begin
                checks++; if (bus.data_o !== 10'(exp_word)) begin errors++; $display("FAIL stream_tail got %0d want %0d", bus.data_o, exp_word); end
                exp_word++;
            end
            step();
        end
        bus.yumi_i = 1'b0;
        checks++; if (exp_word !== 100) begin errors++; $display("FAIL stream_total got %0d want 100", exp_word); end
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL stream_empty got %0d want 0", bus.count_o); end
    endtask

    task automatic test_error_async_reset();
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", bus.err_o); end
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL err_count got %0d want 0", bus.count_o); end
        step();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.err_o); end
        bus.v_i    = 1'b1;
        bus.data_i = 10'h155;
        step();
        bus.data_i = 10'h0AA;
        step();
        bus.v_i = 1'b0;
        checks++; if (bus.count_o !== 2'd2) begin errors++; $display("FAIL prereset_count got %0d want 2", bus.count_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++; if (bus.count_o !== 2'd0) begin errors++; $display("FAIL areset_count got %0d want 0", bus.count_o); end
        checks++; if (bus.v_o !== 1'b0) begin errors++; $display("FAIL areset_v got %b want 0", bus.v_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL areset_err got %b want 0", bus.err_o); end
        checks++; if (bus.data_o !== 10'h000) begin errors++; $display("FAIL areset_data got %h want 000", bus.data_o); end
        step();
        reset_n_i = 1'b1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL post_ready got %b want 1", bus.ready_o); end
        bus.v_i    = 1'b1;
        bus.data_i = 10'h0F0;
        step();
        bus.v_i = 1'b0;
        checks++; if (bus.data_o !== 10'h0F0) begin errors++; $display("FAIL post_data got %h want 0f0", bus.data_o); end
        checks++; if (bus.count_o !== 2'd1) begin errors++; $display("FAIL post_count got %0d want 1", bus.count_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_word();
        test_fill_stall();
        test_full_simul_yumi();
        test_streaming();
        test_error_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
